// File: rtl/hilo_mul_unit.sv
// HI/LO result stage behind the 32x32 unsigned array multiplier: captures operand magnitudes,
// waits LAT cycles (multicycle path), applies sign correction, and serves MTHI/MTLO with stall.
module hilo_mul_unit #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mfhi,
    input  logic        mflo,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        neg_q;
    logic [31:0] op_a_q, op_b_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic [31:0] mag_a_d, mag_b_d;
    logic        neg_d;
    logic [63:0] prod_d;

    // Two's complement magnitude; -2^31 naturally maps to 0x8000_0000.
    always_comb begin
        mag_a_d = rs_data;
        mag_b_d = rt_data;
        neg_d   = 1'b0;
        if (is_signed) begin
            if (rs_data[31]) mag_a_d = ~rs_data + 32'd1;
            if (rt_data[31]) mag_b_d = ~rt_data + 32'd1;
            neg_d = rs_data[31] ^ rt_data[31];
        end
    end

    assign prod_d = neg_q ? (~mul_result + 64'd1) : mul_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
            op_a_q  <= 32'd0;
            op_b_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi) hi_q <= wdata;
                    if (mtlo) lo_q <= wdata;
                    if (start) begin
                        op_a_q  <= mag_a_d;
                        op_b_q  <= mag_b_d;
                        neg_q   <= neg_d;
                        cnt_q   <= LAT_C;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        hi_q    <= prod_d[63:32];
                        lo_q    <= prod_d[31:0];
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = busy & (start | mthi | mtlo | mfhi | mflo);
    assign mul_a = op_a_q;
    assign mul_b = op_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;

endmodule

// File: doc/hilo_mul_unit.md
# hilo_mul_unit

Sequencing and result-holding stage that sits directly downstream of the 32x32 unsigned combinational array multiplier in the CPU datapath. It captures MULT/MULTU operands and drives the multiplier from registers. It waits a fixed number of cycles so the long adder-tree path becomes a multicycle path, applies signed correction, and writes the 64-bit product into the architectural HI/LO registers. It also serves MTHI/MTLO/MFHI/MFLO and raises a pipeline stall when an instruction touches HI/LO while a multiply is in flight.

## Interface
- LAT, 2: cycles from operand capture to HI/LO write; legal range 1..15.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  MULT/MULTU issue, qualified by stall=0.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- rs_data  in  32  operand a.
- rt_data  in  32  operand b.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  32  MTHI/MTLO data.
- mfhi  in  1  MFHI read request; used only for stall.
- mflo  in  1  MFLO read request; used only for stall.
- mul_a  out  32  registered operand magnitude to multiplier input a.
- mul_b  out  32  registered operand magnitude to multiplier input b.
- mul_result  in  64  unsigned product returned by the multiplier.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  multiply in flight.
- stall  out  1  freeze upstream pipeline this cycle.
- done  out  1  one-cycle pulse in the cycle after HI/LO are written by a multiply.

## Operation
- Two states:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter cnt of 4 bits).
- Transitions:
  - IDLE, start=1 at a clock edge: load op_a/op_b, register the negate flag, set cnt=LAT, go to RUN.
  - RUN: cnt decrements each edge.
  - RUN at the edge with cnt==1: HI/LO are loaded from the corrected product, the block returns to IDLE, and done is set.
- Operand capture:
  - MULTU: op_a=rs_data, op_b=rt_data, neg=0.
  - MULT: op_a=|rs_data|, op_b=|rt_data| as 32-bit unsigned magnitudes, neg=rs_data[31]^rt_data[31].
  - -2^31 maps to magnitude 0x8000_0000 with no overflow.
- mul_a=op_a and mul_b=op_b at all times; they hold their value between multiplies.
- Correction: prod = neg ? (~mul_result + 1) mod 2^64 : mul_result; HI=prod[63:32], LO=prod[31:0].
- Zero product with neg=1 yields 0 in both HI and LO.
- stall = busy & (start | mthi | mtlo | mfhi | mflo). It is combinational from inputs and busy.
- start while busy is ignored; the core holds it asserted through the stall.
- IDLE with mthi or mtlo: the register is written at the edge. mthi and mtlo together write both registers.
- IDLE with start and mthi/mtlo in the same cycle: the MT write happens at that edge, and the multiply overwrites HI/LO LAT edges later.
- done=1 for exactly one cycle and is never asserted by MTHI/MTLO.

## Timing
- Reset (rst_n=0, asynchronous) sets:
  - hi=0, lo=0, mul_a=0, mul_b=0.
  - busy=0, done=0, cnt=0, state IDLE.
- Reset mid-operation aborts the multiply; HI/LO return to 0 and no done pulse follows.
- Start accepted at edge E0. busy is high in the LAT cycles following E0. HI/LO update at edge E_LAT. done is high in the cycle after E_LAT.
- Back-to-back: a start presented in the cycle after E_LAT (busy=0) is accepted at the next edge, giving a throughput of one multiply per LAT+1 cycles.
- The multiplier path from op regs to HI/LO is constrained as an LAT-cycle multicycle path.
- hi/lo are register outputs. MFHI/MFLO data is valid in any cycle where stall=0.

## Test plan
- Reset release, no activity -> hi=0, lo=0, busy=0, stall=0, done=0, mul_a=mul_b=0.
- MULTU, LAT=2, rs=0xFFFF_FFFF, rt=0xFFFF_FFFF -> busy high 2 cycles, then hi=0xFFFF_FFFE, lo=0x0000_0001, done one-cycle pulse.
- MULT, rs=0xFFFF_FFFD (-3), rt=0x0000_0007 -> mul_a=3, mul_b=7, hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. Then MULT with rs=rt=0x8000_0000 -> hi=0x4000_0000, lo=0.
- MFHI asserted the cycle after start -> stall=1 until busy falls, then stall=0 with hi holding the new product. start asserted while busy -> stall=1 and no second capture.
- IDLE: mthi wdata=0x1234_5678, next cycle mtlo wdata=0x9ABC_DEF0 -> hi/lo hold those values and done stays 0. Same cycle start (MULTU 2x3) + mthi 0xAAAA_AAAA -> hi=0xAAAA_AAAA after E0, then hi=0, lo=6 at E_LAT.
- Assert rst_n=0 one cycle after a start -> busy=0 and hi=lo=0 immediately. After release, no done pulse and HI/LO stay 0.
